// File: rtl/demultiplexer_1to4_buffered.sv
// One-to-four word router with a one-entry valid/ready holding register per channel.
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1 on the same link.
module demultiplexer_1to4_buffered #(
    parameter int NBits     = 32,
    parameter int CountBits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Selector,
    input  logic [NBits-1:0]     In_Data,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic [NBits-1:0]     Out_Data0,
    output logic [NBits-1:0]     Out_Data1,
    output logic [NBits-1:0]     Out_Data2,
    output logic [NBits-1:0]     Out_Data3,
    output logic [3:0]           Out_Valid,
    input  logic [3:0]           Out_Ready,
    output logic [CountBits-1:0] Word_Count
);

    logic [NBits-1:0]     data_q [4];
    logic [NBits-1:0]     data_d [4];
    logic [3:0]           valid_q;
    logic [3:0]           valid_d;
    logic [CountBits-1:0] count_q;
    logic [CountBits-1:0] count_d;
    logic                 accept;

    // Only the selected channel gates acceptance; a draining channel accepts with no bubble.
    assign In_Ready = ~valid_q[Selector] | Out_Ready[Selector];
    assign accept   = In_Valid & In_Ready;

    always_comb begin
        valid_d = valid_q & ~Out_Ready;
        count_d = count_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
        end
        if (accept) begin
            data_d[Selector]  = In_Data;
            valid_d[Selector] = 1'b1;
            count_d           = count_q + CountBits'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign Out_Data0  = data_q[0];
    assign Out_Data1  = data_q[1];
    assign Out_Data2  = data_q[2];
    assign Out_Data3  = data_q[3];
    assign Out_Valid  = valid_q;
    assign Word_Count = count_q;

endmodule

// File: tb/tb_demultiplexer_1to4_buffered.sv
// Bench for demultiplexer_1to4_buffered: directed scenarios plus random traffic
// checked against per-channel expected queues of capacity one.
module tb_demultiplexer_1to4_buffered;

    logic        clk;
    logic        reset;
    logic [1:0]  Selector;
    logic [31:0] In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Out_Data0, Out_Data1, Out_Data2, Out_Data3;
    logic [3:0]  Out_Valid;
    logic [3:0]  Out_Ready;
    logic [7:0]  Word_Count;

    demultiplexer_1to4_buffered #(.NBits(32), .CountBits(8)) dut (
        .clk(clk), .reset(reset), .Selector(Selector), .In_Data(In_Data),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_Data0(Out_Data0), .Out_Data1(Out_Data1),
        .Out_Data2(Out_Data2), .Out_Data3(Out_Data3),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Word_Count(Word_Count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [4][$];
    logic [7:0]  exp_cnt = 8'h00;
    logic        mon_en = 1'b0;
    logic        model_acc = 1'b0;
    logic [31:0] od [4];

    assign od[0] = Out_Data0;
    assign od[1] = Out_Data1;
    assign od[2] = Out_Data2;
    assign od[3] = Out_Data3;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard monitor: compare before the edge, then advance the model for that edge
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_ready;
            logic full [4];
            for (int k = 0; k < 4; k++) begin
                full[k] = (exp_q[k].size() != 0);
                check($sformatf("out_valid%0d", k), {31'b0, Out_Valid[k]}, {31'b0, full[k]});
                if (full[k]) check($sformatf("out_data%0d", k), od[k], exp_q[k][0]);
            end
            exp_ready = !full[Selector] || Out_Ready[Selector];
            if (In_Valid) check("in_ready", {31'b0, In_Ready}, {31'b0, exp_ready});
            check("word_count", {24'b0, Word_Count}, {24'b0, exp_cnt});
            for (int k = 0; k < 4; k++) begin
                if (full[k] && Out_Ready[k]) void'(exp_q[k].pop_front());
            end
            model_acc = In_Valid && exp_ready;
            if (model_acc) begin
                exp_q[Selector].push_back(In_Data);
                exp_cnt = exp_cnt + 8'd1;
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        In_Valid  = v;
        Selector  = s;
        In_Data   = d;
        Out_Ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        In_Valid  = 1'b0;
        Out_Ready = 4'h0;
        mon_en    = 1'b0;
        reset     = 1'b0;
        #1;
        check("rst_valid", {28'b0, Out_Valid}, 32'h0);
        check("rst_count", {24'b0, Word_Count}, 32'h0);
        for (int k = 0; k < 4; k++) check($sformatf("rst_data%0d", k), od[k], 32'h0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        exp_cnt = 8'h00;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!(In_Valid && !model_acc)) begin
                In_Valid = ($urandom_range(0, 3) != 0);
                Selector = 2'($urandom_range(0, 3));
                In_Data  = $urandom;
            end
            Out_Ready = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] start_cnt;
        reset = 1'b0; In_Valid = 1'b0; Selector = 2'd0; In_Data = '0; Out_Ready = 4'h0;
        @(posedge clk);
        #1;
        do_reset();

        // single route
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'h0);
        check("single_data2", Out_Data2, 32'hDEADBEEF);
        check("single_valid", {28'b0, Out_Valid}, 32'h4);
        check("single_count", {24'b0, Word_Count}, 32'h1);
        step(1'b0, 2'd0, 32'h0, 4'hF);

        // backpressure on channel 1, then same-cycle drain and reload
        step(1'b1, 2'd1, 32'hAA, 4'h0);
        repeat (3) step(1'b1, 2'd1, 32'h11, 4'h0);
        check("bp_hold_data1", Out_Data1, 32'hAA);
        step(1'b1, 2'd1, 32'h11, 4'h2);
        check("bp_reload_data1", Out_Data1, 32'h11);
        check("bp_reload_valid", {28'b0, Out_Valid}, 32'h2);
        step(1'b0, 2'd0, 32'h0, 4'hF);

        // a full stalled channel does not block another
        step(1'b1, 2'd0, 32'h00, 4'h0);
        step(1'b1, 2'd3, 32'h33, 4'h0);
        check("nb_valid", {28'b0, Out_Valid}, 32'h9);
        check("nb_data3", Out_Data3, 32'h33);

        // asynchronous reset mid-run with channels 1 and 3 full
        step(1'b0, 2'd0, 32'h0, 4'hF);
        step(1'b1, 2'd1, 32'h5A, 4'h0);
        step(1'b1, 2'd3, 32'hA5, 4'h0);
        check("pre_rst_valid", {28'b0, Out_Valid}, 32'hA);
        do_reset();

        // throughput: eight words, no stalls
        start_cnt = exp_cnt;
        for (int i = 1; i <= 8; i++) step(1'b1, 2'((i - 1) % 4), 32'(i), 4'hF);
        check("thru_count", {24'b0, Word_Count}, {24'b0, start_cnt + 8'd8});
        step(1'b0, 2'd0, 32'h0, 4'hF);

        rand_phase(400);
        step(1'b0, 2'd0, 32'h0, 4'hF);

        // counter wrap after 256 accepts
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 2'(i % 4), $urandom, 4'hF);
        check("wrap_count", {24'b0, Word_Count}, 32'h0);
        step(1'b0, 2'd0, 32'h0, 4'hF);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demultiplexer_1to4_buffered.md
Name: demultiplexer_1to4_buffered

Overview:
One-to-four routing block: the inverse of the datapath 4-to-1 multiplexer. It takes one NBits word plus a 2-bit Selector and delivers the word to the chosen output channel. Each channel has a one-entry holding register with a valid/ready handshake. A word is accepted only when its destination channel can take it. Used wherever one producer feeds four consumers, for example writeback fan-out or peripheral data routing.

Parameters:
NBits, 32, data word width of the input and of each output channel.
CountBits, 8, width of the accepted-word counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
Selector  input  2  destination channel for In_Data: 0..3 selects Out_Data0..Out_Data3. Sampled only while In_Valid=1.
In_Data  input  NBits  word to route.
In_Valid  input  1  producer offers In_Data/Selector this cycle.
In_Ready  output  1  block accepts the offered word this cycle.
Out_Data0  output  NBits  channel 0 holding register.
Out_Data1  output  NBits  channel 1 holding register.
Out_Data2  output  NBits  channel 2 holding register.
Out_Data3  output  NBits  channel 3 holding register.
Out_Valid  output  4  bit k=1: Out_Datak holds an undelivered word.
Out_Ready  input  4  bit k=1: consumer k takes Out_Datak this cycle.
Word_Count  output  CountBits  total words accepted since reset.

Behaviour:
- Reset is asynchronous on reset=0: Out_Valid=4'b0000, Out_Data0..3=0, Word_Count=0. Any in-flight words are discarded. Registers stay at reset values while reset=0. Normal operation resumes on the first rising clk edge after reset returns to 1.
- In_Ready is combinational: In_Ready = ~Out_Valid[Selector] | Out_Ready[Selector]. This is a pass-through path from Out_Ready to In_Ready, with no bubble when the destination channel is drained in the same cycle.
- In_Ready depends only on the selected channel. Full channels other than the selected one do not block.
- A word is accepted at the rising edge when In_Valid=1 and In_Ready=1. On acceptance:
  - Out_Data[Selector] <= In_Data.
  - Out_Valid[Selector] <= 1.
  - Word_Count <= Word_Count+1. The counter wraps modulo 2^CountBits, so 8'hFF goes to 8'h00.
- Latency: a word accepted at edge N is visible on Out_Datak with Out_Validk=1 immediately after edge N.
- Channel k delivers at an edge where Out_Valid[k]=1 and Out_Ready[k]=1. With no simultaneous acceptance into k, Out_Valid[k] <= 0.
- Out_Datak keeps its last value after delivery. Consumers ignore Out_Datak whenever Out_Valid[k]=0.
- Simultaneous deliver and accept on the same channel k: the register is reloaded with the new word and Out_Valid[k] stays 1. No word is lost or duplicated.
- Delivery on channel j and acceptance into channel k (j≠k) in the same cycle are independent. All four channels may deliver in the same cycle.
- Out_Ready[k] while Out_Valid[k]=0 has no effect.
- Holding rules:
  - A producer stalled with In_Ready=0 holds In_Data and Selector stable until acceptance.
  - Once Out_Valid[k]=1, Out_Datak stays constant until that word is delivered.
- While In_Valid=0, Selector and In_Data may be X. In_Ready is then don't-care, and no state changes except deliveries.
- No internal ordering across channels. Order within one channel is preserved (trivially, depth 1).

Test Plan:
- Reset: assert reset=0 mid-run with Out_Valid=4'b1010 -> Out_Valid=0, all Out_Data=0, Word_Count=0 immediately, without waiting for a clock edge.
- Single route: In_Valid=1, Selector=2, In_Data=32'hDEADBEEF, Out_Ready=0 -> after 1 edge Out_Data2=32'hDEADBEEF, Out_Valid=4'b0100, Word_Count=1. Other channels unchanged.
- Backpressure: channel 1 full and Out_Ready[1]=0, offer Selector=1, 32'h11 -> In_Ready=0 for 3 cycles with no change. Raise Out_Ready[1] -> In_Ready=1 the same cycle. The next edge loads 32'h11 and Out_Valid[1] stays 1.
- Non-blocking: channel 0 full and stalled, offer Selector=3, 32'h33 -> In_Ready=1 and it is accepted. Out_Valid=4'b1001.
- Throughput: Selector cycles 0,1,2,3 with Out_Ready=4'hF and data 1..8 over 8 cycles -> 8 accepts with no stalls. Each channel sees its two words in order. Word_Count=8.
- Wrap: 256 accepted words -> Word_Count returns to 8'h00.
